// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the NN datapath.
// Used by the activation stage and the layer MAC stage.
package nn_fixed_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int FRAC_W_DEF = 4;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/interp_sat_add.sv
// Combinational interpolation: base + (diff * frac) >>> FRAC_W,
// clamped to the signed sample range.
module interp_sat_add
    import nn_fixed_pkg::*;
#(
    parameter int DATA_W = nn_fixed_pkg::DATA_W_DEF,
    parameter int FRAC_W = nn_fixed_pkg::FRAC_W_DEF
) (
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W:0]   diff,
    input  logic        [FRAC_W-1:0] frac,
    output logic signed [DATA_W-1:0] sum
);

    localparam int PW = DATA_W + FRAC_W + 2;
    localparam int SW = DATA_W + 2;

    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] delta;
    logic signed [SW-1:0] sum_w;
    logic signed [31:0]   wide;

    // frac is zero-extended so it always acts as a non-negative weight.
    assign prod  = $signed({{(PW-DATA_W-1){diff[DATA_W]}}, diff})
                 * $signed({{(PW-FRAC_W){1'b0}}, frac});
    assign delta = SW'(prod >>> FRAC_W);
    assign sum_w = $signed({{2{base[DATA_W-1]}}, base}) + delta;
    assign wide  = $signed({{(32-SW){sum_w[SW-1]}}, sum_w});
    assign sum   = DATA_W'(saturate(wide, DATA_W));

endmodule

// File: rtl/activation_interp.sv
// Three-stage piecewise-linear activation with LUT interpolation.
// All stages advance together; a blocked output freezes the pipe.
module activation_interp
    import nn_fixed_pkg::*;
#(
    parameter int DATA_W = nn_fixed_pkg::DATA_W_DEF,
    parameter int ADDR_W = nn_fixed_pkg::ADDR_W_DEF,
    parameter int FRAC_W = nn_fixed_pkg::FRAC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic        [ADDR_W-1:0] lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic                     en;
    logic signed [DATA_W-1:0] s1_x;
    logic                     s1_v;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W:0]   diff;
    logic        [FRAC_W-1:0] frac;
    logic                     s2_v;
    logic signed [DATA_W-1:0] sat_sum;

    assign en          = !out_valid || out_ready;
    assign in_ready    = en;
    assign lut_address = s1_x[DATA_W-1 -: ADDR_W];

    // S1: capture the raw sample; its upper bits address the LUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_x <= '0;
            s1_v <= 1'b0;
        end else if (en) begin
            s1_x <= in_data;
            s1_v <= in_valid;
        end
    end

    // S2: latch the LUT pair as base plus slope, and the fraction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base <= '0;
            diff <= '0;
            frac <= '0;
            s2_v <= 1'b0;
        end else if (en) begin
            base <= lut_base;
            diff <= $signed({lut_next[DATA_W-1], lut_next})
                  - $signed({lut_base[DATA_W-1], lut_base});
            frac <= s1_x[FRAC_W-1:0];
            s2_v <= s1_v;
        end
    end

    interp_sat_add #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_sat_add (
        .base (base),
        .diff (diff),
        .frac (frac),
        .sum  (sat_sum)
    );

    // S3: register the saturated interpolation toward the next layer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_data  <= sat_sum;
            out_valid <= s2_v;
        end
    end

endmodule
